dqs_burst_sequencer: RTL

Registered two-lane DQS strobe sequencer and loopback checker that sits directly upstream of the differential DQS I/O buffer pair. It drives `dqs_data` and `dqs_tri` in the order preamble, toggle burst, postamble, and then releases the pad. It compares the returned `dqs_received` against the pattern it drove, delayed by a fixed number of cycles, and counts mismatches. It is used to bring up and characterise the DQS pads before the full PHY is attached.

---
 rtl/dqs_burst_sequencer_if.sv | 25 ++
 rtl/dqs_burst_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dqs_burst_sequencer_if.sv
// Bus bundle between the DQS burst sequencer and whatever drives/observes it.
// The slave modport is the sequencer side; the master side issues requests and returns pad data.
interface dqs_burst_sequencer_if #(
    parameter int ERR_WIDTH = 16
);
    logic                 start;
    logic [1:0]           lane_en;
    logic                 clr_err;
    logic [1:0]           dqs_data;
    logic [1:0]           dqs_tri;
    logic [1:0]           dqs_received;
    logic                 busy;
    logic                 done;
    logic [ERR_WIDTH-1:0] err_cnt;

    modport master (
        output start, lane_en, clr_err, dqs_received,
        input  dqs_data, dqs_tri, busy, done, err_cnt
    );

    modport slave (
        input  start, lane_en, clr_err, dqs_received,
        output dqs_data, dqs_tri, busy, done, err_cnt
    );
endinterface

// File: rtl/dqs_burst_sequencer.sv
// Two-lane DQS strobe sequencer (preamble, toggle burst, postamble) with a
// delayed loopback checker that counts mismatching cycles into a saturating counter.
module dqs_burst_sequencer #(
    parameter int BURST_LEN        = 8,
    parameter int PREAMBLE_CYCLES  = 1,
    parameter int POSTAMBLE_CYCLES = 1,
    parameter int CHECK_DELAY      = 2,
    parameter int ERR_WIDTH        = 16
) (
    input logic                  clk,
    input logic                  rst,
    dqs_burst_sequencer_if.slave bus
);

    localparam int unsigned DEPTH = CHECK_DELAY;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        BURST,
        POST
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [1:0] lanes, lanes_nxt;

    logic [1:0] tri_d, data_d, en_d;
    logic       busy_d, done_d;

    logic [1:0] dqs_data_q, dqs_tri_q;
    logic       busy_q, done_q;

    logic [1:0]           pipe_data [DEPTH];
    logic [1:0]           pipe_en   [DEPTH];
    logic                 err_hit;
    logic [ERR_WIDTH-1:0] err_cnt_q;

    // State register; outputs are registered from the next-state values so the
    // pads change on the same edge that the state does.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lanes      <= '0;
            dqs_data_q <= '0;
            dqs_tri_q  <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            lanes      <= lanes_nxt;
            dqs_data_q <= data_d;
            dqs_tri_q  <= tri_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lanes_nxt = lanes;
        case (state)
            IDLE: begin
                if (bus.start && (bus.lane_en != 2'b00)) begin
                    state_nxt = PRE;
                    cnt_nxt   = '0;
                    lanes_nxt = bus.lane_en;
                end
            end
            PRE: begin
                if (cnt == 8'(PREAMBLE_CYCLES - 1)) begin
                    state_nxt = BURST;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            BURST: begin
                if (cnt == 8'(BURST_LEN - 1)) begin
                    state_nxt = POST;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            POST: begin
                if (cnt == 8'(POSTAMBLE_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Burst phase is 1 on even beat indices, so the first beat is high and the last is low.
    always_comb begin
        tri_d  = '1;
        data_d = '0;
        en_d   = '0;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_nxt != IDLE) begin
            tri_d  = ~lanes_nxt;
            en_d   = lanes_nxt;
            busy_d = 1'b1;
        end
        if ((state_nxt == BURST) && !cnt_nxt[0]) begin
            data_d = lanes_nxt;
        end
        if ((state == POST) && (state_nxt == IDLE)) begin
            done_d = 1'b1;
        end
    end

    // Stage 0 loads together with the pad outputs; the last stage lines up with
    // dqs_received CHECK_DELAY edges later, and the hit is counted one edge after that.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_data[i] <= '0;
                pipe_en[i]   <= '0;
            end
            err_hit   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            pipe_data[0] <= data_d;
            pipe_en[0]   <= en_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_data[i] <= pipe_data[i-1];
                pipe_en[i]   <= pipe_en[i-1];
            end
            err_hit <= |(pipe_en[DEPTH-1] & (bus.dqs_received ^ pipe_data[DEPTH-1]));
            if (bus.clr_err) begin
                err_cnt_q <= '0;
            end else if (err_hit && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign bus.dqs_data = dqs_data_q;
    assign bus.dqs_tri  = dqs_tri_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err_cnt  = err_cnt_q;

endmodule
